ap_mult_err_eval: RTL and testbench
===================================

// Module: ap_mult_err_eval
// PURPOSE
//  Exhaustive error-evaluation stage wrapped around one combinational approximate unsigned multiplier.
//  Upstream role: sweeps every operand pair and drives muld/mulr into the multiplier.
//  Downstream role: takes the multiplier's res and scores it against the exact product.
//  Accumulates sum of |error|, max |error| and count of erroneous pairs.
//  Used in the evo flow to score each candidate multiplier on silicon or in simulation.
// PARAMETERS
//  DW      4        operand width; sweep covers 2^(2*DW) pairs
//  PW      2*DW     product width (derived, do not override)
//  SW      4*DW     err_sum width (derived)
// PORTS
//  clk         in   1       system clock
//  rst_n       in   1       async active-low reset
//  start       in   1       1-cycle request; starts a sweep
//  op_a        out  DW      multiplicand to multiplier (muld)
//  op_b        out  DW      multiplier to multiplier (mulr)
//  ap_res      in   PW      approximate product of op_a*op_b, combinational, same cycle
//  busy        out  1       high in RUN and DRAIN
//  done        out  1       1-cycle pulse on entering DONE
//  err_sum     out  SW      sum over all pairs of |op_a*op_b - ap_res|
//  err_max     out  PW      maximum |error|
//  err_cnt     out  PW+1    number of pairs with nonzero error
//  err_sq_sum  out  6*DW    sum of squared error (only with AP_ERR_SQ_EN)
// BEHAVIOUR
//  Reset: one clock; reset is asynchronous and active-low on rst_n. All outputs, counters, state and accumulators reset to 0. State resets to IDLE.
//  FSM states: IDLE, RUN, DRAIN, DONE.
//   IDLE or DONE + start -> RUN. idx, op_a, op_b and all accumulators clear on the same edge.
//   RUN -> DRAIN on the edge that samples pair idx = 2^(2*DW)-1.
//   DRAIN lasts 2 cycles, then -> DONE.
//   DONE holds results until the next start. DONE never exits on its own.
//  Operand order: op_a = idx[DW-1:0], op_b = idx[PW-1:DW]. op_a/op_b are registered and idx increments by 1 per RUN cycle.
//  Pipeline:
//   S0: ap_res is sampled together with the exact product op_a*op_b. e = |exact - ap_res|, PW bits.
//   S1: e is registered with a valid bit.
//   S2: accumulate.
//    err_sum += e (no wrap possible at SW).
//    err_max = max(err_max, e).
//    err_cnt += (e != 0).
//  Latency: done is high in the cycle following the 2^(2*DW)+2-th edge after start is sampled (258 for DW=4). Results are valid whenever done or DONE.
//  start while busy: ignored, no restart, no accumulator disturbance.
//  Reset mid-sweep: immediate return to IDLE. Partial results are discarded (zeros).
//  Outside RUN: op_a/op_b hold their last value. ap_res is don't-care.
// CONFIGURATION
//  AP_ERR_SQ_EN defined:
//   err_sq_sum port and accumulator exist. err_sq_sum += e*e in S2.
//   A 1-deep multiplier register is added at S1 so S2 latency is unchanged.
//  AP_ERR_SQ_EN undefined: port and logic absent. All other behaviour is identical.
// STRUCTURE
//  Shared package/header ap_mult_pkg:
//   DW default, PW/SW width macros.
//   FSM state encodings ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE.
//  Sub-module ap_err_acc: S1/S2 register and accumulate slice.
//   Inputs: e, valid, clr. Outputs: sum/max/cnt(/sq).
//   Top keeps FSM, idx counter, exact product, abs-diff.
//  The multiplier under test is instantiated outside, in the bench or top, and connected op_a->muld, op_b->mulr, res->ap_res.
// TESTING
//  T1 ap_res = exact product, start -> done at +258 clk. err_sum=0, err_max=0, err_cnt=0.
//  T2 ap_res tied 0 -> err_sum=14400, err_max=225, err_cnt=225. err_sq_sum=1537600 with AP_ERR_SQ_EN.
//  T3 ap_res = exact ^ 8'h01 -> err_sum=256, err_max=1, err_cnt=256.
//  T4 extra start pulses mid-RUN; also a start in DONE -> first sweep result unchanged. Second sweep restarts from idx 0 and gives identical values.
//  T5 rst_n low at idx 100 -> all outputs 0, IDLE. Next start gives full-sweep T2 values.
//  T6 ap_res = actual ap_unsi_wall_4b_r2 -> values match a golden model over all 256 pairs. done pulses exactly 1 cycle.

Source files
------------

// File: rtl/ap_mult_pkg.sv
// Shared widths and FSM encoding for the approximate-multiplier error evaluator.
// Derived widths are helper functions so every file computes them identically.
package ap_mult_pkg;

  localparam int AP_DW = 4;

  function automatic int pw_of(input int dw);
    return 2 * dw;
  endfunction

  function automatic int sw_of(input int dw);
    return 4 * dw;
  endfunction

  function automatic int sqw_of(input int dw);
    return 6 * dw;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ap_state_e;

endpackage

// File: rtl/ap_err_acc.sv
// S1 register and S2 accumulate slice: sum, max and nonzero count of |error|.
// AP_ERR_SQ_EN adds a registered e*e product at S1 and a squared-error sum at S2.
module ap_err_acc
  import ap_mult_pkg::*;
#(
  parameter int DW = AP_DW,
  localparam int PW = pw_of(DW),
`ifdef AP_ERR_SQ_EN
  localparam int QW = sqw_of(DW),
`endif
  localparam int SW = sw_of(DW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          valid,
  input  logic [PW-1:0] e,
  output logic [SW-1:0] sum,
  output logic [PW-1:0] max,
  output logic [PW:0]   cnt
`ifdef AP_ERR_SQ_EN
  ,
  output logic [QW-1:0] sq
`endif
);

  logic          valid_q;
  logic [PW-1:0] e_q;
  logic [SW-1:0] sum_q, sum_d;
  logic [PW-1:0] max_q, max_d;
  logic [PW:0]   cnt_q, cnt_d;

`ifdef AP_ERR_SQ_EN
  logic [2*PW-1:0] sq_prod_q, sq_prod_d;
  logic [QW-1:0]   sq_q, sq_d;

  assign sq_prod_d = {{PW{1'b0}}, e} * {{PW{1'b0}}, e};
`endif

  always_comb begin
    sum_d = sum_q;
    max_d = max_q;
    cnt_d = cnt_q;
`ifdef AP_ERR_SQ_EN
    sq_d  = sq_q;
`endif
    if (clr) begin
      sum_d = '0;
      max_d = '0;
      cnt_d = '0;
`ifdef AP_ERR_SQ_EN
      sq_d  = '0;
`endif
    end else if (valid_q) begin
      sum_d = sum_q + SW'(e_q);
      max_d = (e_q > max_q) ? e_q : max_q;
      cnt_d = cnt_q + (PW+1)'(e_q != '0);
`ifdef AP_ERR_SQ_EN
      sq_d  = sq_q + QW'(sq_prod_q);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      e_q       <= '0;
      sum_q     <= '0;
      max_q     <= '0;
      cnt_q     <= '0;
`ifdef AP_ERR_SQ_EN
      sq_prod_q <= '0;
      sq_q      <= '0;
`endif
    end else begin
      valid_q   <= valid & ~clr;
      e_q       <= clr ? '0 : e;
      sum_q     <= sum_d;
      max_q     <= max_d;
      cnt_q     <= cnt_d;
`ifdef AP_ERR_SQ_EN
      sq_prod_q <= clr ? '0 : sq_prod_d;
      sq_q      <= sq_d;
`endif
    end
  end

  assign sum = sum_q;
  assign max = max_q;
  assign cnt = cnt_q;
`ifdef AP_ERR_SQ_EN
  assign sq  = sq_q;
`endif

endmodule

// File: rtl/ap_mult_err_eval.sv
// Exhaustive sweep + error scoring around an external combinational approximate multiplier.
// Define AP_ERR_SQ_EN to add the err_sq_sum port and squared-error accumulator.
module ap_mult_err_eval
  import ap_mult_pkg::*;
#(
  parameter int DW = AP_DW,
  localparam int PW = pw_of(DW),
`ifdef AP_ERR_SQ_EN
  localparam int QW = sqw_of(DW),
`endif
  localparam int SW = sw_of(DW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  input  logic [PW-1:0] ap_res,
  output logic          busy,
  output logic          done,
  output logic [SW-1:0] err_sum,
  output logic [PW-1:0] err_max,
  output logic [PW:0]   err_cnt
`ifdef AP_ERR_SQ_EN
  ,
  output logic [QW-1:0] err_sq_sum
`endif
);

  localparam logic [PW-1:0] IDX_LAST = '1;

  ap_state_e     state_q, state_d;
  logic [PW-1:0] idx_q, idx_d;
  logic          drain_q, drain_d;
  logic          done_q, done_d;
  logic          clr;
  logic          s0_valid;
  logic [PW-1:0] exact;
  logic [PW-1:0] e;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    drain_d  = drain_q;
    done_d   = 1'b0;
    clr      = 1'b0;
    s0_valid = (state_q == ST_RUN);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          idx_d   = '0;
          drain_d = 1'b0;
          clr     = 1'b1;
        end
      end
      ST_RUN: begin
        // idx parks on the last pair so op_a/op_b hold it after the sweep
        if (idx_q == IDX_LAST) begin
          state_d = ST_DRAIN;
          drain_d = 1'b0;
        end else begin
          idx_d = idx_q + PW'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      drain_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
      done_q  <= done_d;
    end
  end

  assign op_a = idx_q[DW-1:0];
  assign op_b = idx_q[PW-1:DW];
  assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done = done_q;

  assign exact = {{DW{1'b0}}, op_a} * {{DW{1'b0}}, op_b};
  assign e     = (exact >= ap_res) ? (exact - ap_res) : (ap_res - exact);

  ap_err_acc #(
    .DW(DW)
  ) u_acc (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .valid(s0_valid),
    .e    (e),
    .sum  (err_sum),
    .max  (err_max),
    .cnt  (err_cnt)
`ifdef AP_ERR_SQ_EN
    ,
    .sq   (err_sq_sum)
`endif
  );

endmodule

// File: tb/tb_ap_mult_err_eval.sv
// Directed bench for ap_mult_err_eval: sweep-level model with per-cycle comparison.
// Honors AP_ERR_SQ_EN for the optional squared-error output.
module tb_ap_mult_err_eval;

  localparam int LAT = 258;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [3:0] op_a, op_b;
  logic [7:0] ap_res;
  logic       busy, done;
  logic [15:0] err_sum;
  logic [7:0]  err_max;
  logic [8:0]  err_cnt;
`ifdef AP_ERR_SQ_EN
  logic [23:0] err_sq_sum;
`endif

  int mode = 0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Multiplier under test: 0 exact, 1 tied zero, 2 exact^1, 3 truncated low columns.
  function automatic int apx(input int m, input int a, input int b);
    int r;
    r = 0;
    case (m)
      0: r = a * b;
      1: r = 0;
      2: r = (a * b) ^ 1;
      default: begin
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++)
            if ((i + j >= 2) && a[i] && b[j]) r += (1 << (i + j));
      end
    endcase
    return r;
  endfunction

  assign ap_res = 8'(apx(mode, int'(op_a), int'(op_b)));

  function automatic longint stat(input int m, input int which);
    longint s, mx, c, q;
    int e;
    s = 0; mx = 0; c = 0; q = 0;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        e = a * b - apx(m, a, b);
        if (e < 0) e = -e;
        s += e;
        if (e > mx) mx = e;
        if (e != 0) c++;
        q += e * e;
      end
    case (which)
      0: return s;
      1: return mx;
      2: return c;
      default: return q;
    endcase
  endfunction

  ap_mult_err_eval #(.DW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .ap_res    (ap_res),
    .busy      (busy),
    .done      (done),
    .err_sum   (err_sum),
    .err_max   (err_max),
    .err_cnt   (err_cnt)
`ifdef AP_ERR_SQ_EN
    ,
    .err_sq_sum(err_sq_sum)
`endif
  );

  // Sweep model: phase 0 = no sweep since reset, rel = edges since accepted start.
  int     phase = 0;
  int     rel = 0;
  int     exp_mode = 0;
  longint exp_sum = 0, exp_max = 0, exp_cnt = 0, exp_sq = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 0;
      rel   <= 0;
    end else if (start && (phase == 0 || rel >= LAT)) begin
      phase    <= 1;
      rel      <= 0;
      exp_mode <= mode;
      exp_sum  <= stat(mode, 0);
      exp_max  <= stat(mode, 1);
      exp_cnt  <= stat(mode, 2);
      exp_sq   <= stat(mode, 3);
    end else if (phase == 1 && rel < 100000) begin
      rel <= rel + 1;
    end
  end

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (rel=%0d t=%0t)", nm, act, expv, rel, $time);
    end
  endtask

  always @(negedge clk) begin
    int idx;
    if (phase == 0) begin
      chk("idle_busy", longint'(busy), 0);
      chk("idle_done", longint'(done), 0);
      chk("idle_op_a", longint'(op_a), 0);
      chk("idle_op_b", longint'(op_b), 0);
      chk("idle_sum", longint'(err_sum), 0);
      chk("idle_max", longint'(err_max), 0);
      chk("idle_cnt", longint'(err_cnt), 0);
`ifdef AP_ERR_SQ_EN
      chk("idle_sq", longint'(err_sq_sum), 0);
`endif
    end else begin
      idx = (rel > 255) ? 255 : rel;
      chk("busy", longint'(busy), longint'(rel < LAT));
      chk("done", longint'(done), longint'(rel == LAT));
      chk("op_a", longint'(op_a), longint'(idx % 16));
      chk("op_b", longint'(op_b), longint'(idx / 16));
      if (rel <= 1) begin
        chk("clr_sum", longint'(err_sum), 0);
        chk("clr_max", longint'(err_max), 0);
        chk("clr_cnt", longint'(err_cnt), 0);
      end
      if (rel >= LAT) begin
        chk("sum", longint'(err_sum), exp_sum);
        chk("max", longint'(err_max), exp_max);
        chk("cnt", longint'(err_cnt), exp_cnt);
`ifdef AP_ERR_SQ_EN
        chk("sq", longint'(err_sq_sum), exp_sq);
`endif
      end
      if (rel == LAT) begin
        $display("sweep mode=%0d sum=%0d max=%0d cnt=%0d", exp_mode, err_sum, err_max, err_cnt);
        case (exp_mode)
          0: begin
            chk("lit_exact_sum", longint'(err_sum), 0);
            chk("lit_exact_max", longint'(err_max), 0);
            chk("lit_exact_cnt", longint'(err_cnt), 0);
          end
          1: begin
            chk("lit_zero_sum", longint'(err_sum), 14400);
            chk("lit_zero_max", longint'(err_max), 225);
            chk("lit_zero_cnt", longint'(err_cnt), 225);
`ifdef AP_ERR_SQ_EN
            chk("lit_zero_sq", longint'(err_sq_sum), 1537600);
`endif
          end
          2: begin
            chk("lit_xor_sum", longint'(err_sum), 256);
            chk("lit_xor_max", longint'(err_max), 1);
            chk("lit_xor_cnt", longint'(err_cnt), 256);
          end
          default: ;
        endcase
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_sweep(input int m);
    mode = m;
    pulse_start();
    repeat (LAT + 3) @(negedge clk);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    run_sweep(0);
    run_sweep(1);
    run_sweep(2);

    // Starts while busy (RUN twice, DRAIN once) must be ignored
    mode = 1;
    pulse_start();
    repeat (49) @(negedge clk);
    pulse_start();
    repeat (148) @(negedge clk);
    pulse_start();
    repeat (54) @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    // Restart from DONE
    run_sweep(1);

    // Reset mid-sweep, then a clean sweep
    mode = 1;
    pulse_start();
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_sweep(1);

    run_sweep(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
